// File: rtl/iris_pkg.sv
// rtl/iris_pkg.sv - shared types and constants for the IRIS modulation scheduler
package iris_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN_L = 2'd2,
        RUN_H = 2'd3
    } state_t;

    // Shortest half period that still leaves room for trig, settle and one sample
    localparam int unsigned MIN_HALF = 4;

endpackage

// File: rtl/iris_mod_sched_if.sv
// rtl/iris_mod_sched_if.sv - control/status bundle between host logic and the scheduler
interface iris_mod_sched_if #(
    parameter int CNT_W = 32
);
    logic             i_enable;
    logic             i_cfg_load;
    logic [CNT_W-1:0] i_half_period;
    logic [CNT_W-1:0] i_wait_cnt;
    logic [4:0]       i_avg_sel;

    logic             o_status;
    logic             o_trig;
    logic             o_mod;
    logic [CNT_W-1:0] o_wait_cnt;
    logic [31:0]      o_avg_sel;
    logic             o_period_done;
    logic             o_cfg_ack;
    logic             o_cfg_err;

    modport master (
        output i_enable, i_cfg_load, i_half_period, i_wait_cnt, i_avg_sel,
        input  o_status, o_trig, o_mod, o_wait_cnt, o_avg_sel,
               o_period_done, o_cfg_ack, o_cfg_err
    );

    modport slave (
        input  i_enable, i_cfg_load, i_half_period, i_wait_cnt, i_avg_sel,
        output o_status, o_trig, o_mod, o_wait_cnt, o_avg_sel,
               o_period_done, o_cfg_ack, o_cfg_err
    );

endinterface

// File: rtl/iris_cfg_check.sv
// rtl/iris_cfg_check.sv - combinational validator for a pending timing config
module iris_cfg_check
    import iris_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MAX_AVG_SEL = 10
) (
    input  logic [CNT_W-1:0] half_i,
    input  logic [CNT_W-1:0] wait_i,
    input  logic [4:0]       avg_i,
    output logic             ok_o
);
    // Two guard bits keep wait + 2^avg + 2 from wrapping back into a small value
    localparam int XW = CNT_W + 2;

    logic [XW-1:0] half_x;
    logic [XW-1:0] need_x;

    // Settle time plus the averaging window plus trig overhead must fit in one half
    always_comb begin
        half_x = {2'b00, half_i};
        need_x = {2'b00, wait_i} + (XW'(1) << avg_i) + XW'(2);
        ok_o   = (half_x >= XW'(MIN_HALF))
              && (avg_i <= 5'(MAX_AVG_SEL))
              && (need_x <= half_x);
    end

endmodule

// File: rtl/iris_mod_sched.sv
// rtl/iris_mod_sched.sv - square-wave modulation and acquisition trigger scheduler
module iris_mod_sched
    import iris_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MAX_AVG_SEL = 10,
    parameter int DEF_HALF    = 1000,
    parameter int DEF_WAIT    = 100,
    parameter int DEF_AVG     = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    iris_mod_sched_if.slave bus
);
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;

    logic [CNT_W-1:0] act_half_q;
    logic [CNT_W-1:0] act_wait_q;
    logic [4:0]       act_avg_q;

    logic [CNT_W-1:0] pend_half_q;
    logic [CNT_W-1:0] pend_wait_q;
    logic [4:0]       pend_avg_q;
    logic             pend_q;

    logic             status_q;
    logic             trig_q;
    logic             mod_q;
    logic             done_q;
    logic             ack_q;
    logic             err_q;

    logic             cfg_ok;
    logic             half_end;
    logic             apply_d;
    logic [CNT_W-1:0] half_d;

    iris_cfg_check #(
        .CNT_W       (CNT_W),
        .MAX_AVG_SEL (MAX_AVG_SEL)
    ) u_cfg_check (
        .half_i (pend_half_q),
        .wait_i (pend_wait_q),
        .avg_i  (pend_avg_q),
        .ok_o   (cfg_ok)
    );

    // Pending config is consumed only when a run starts or a full period ends,
    // and half_d is the half length the next RUN_L must use after that apply
    always_comb begin
        half_end = (cnt_q == '0);
        apply_d  = pend_q && (((state_q == IDLE) && bus.i_enable)
                           || ((state_q == RUN_H) && half_end));
        half_d   = (apply_d && cfg_ok) ? pend_half_q : act_half_q;
    end

    // Double-buffered config: a load in the apply cycle becomes the new pending
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            act_half_q  <= CNT_W'(DEF_HALF);
            act_wait_q  <= CNT_W'(DEF_WAIT);
            act_avg_q   <= 5'(DEF_AVG);
            pend_half_q <= '0;
            pend_wait_q <= '0;
            pend_avg_q  <= '0;
            pend_q      <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            if (apply_d) begin
                pend_q <= 1'b0;
                if (cfg_ok) begin
                    act_half_q <= pend_half_q;
                    act_wait_q <= pend_wait_q;
                    act_avg_q  <= pend_avg_q;
                    ack_q      <= 1'b1;
                    err_q      <= 1'b0;
                end else begin
                    err_q      <= 1'b1;
                end
            end
            if (bus.i_cfg_load) begin
                pend_half_q <= bus.i_half_period;
                pend_wait_q <= bus.i_wait_cnt;
                pend_avg_q  <= bus.i_avg_sel;
                pend_q      <= 1'b1;
            end
        end
    end

    // Run-state machine; outputs are set one cycle ahead so they line up with the state they describe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            status_q <= 1'b0;
            trig_q   <= 1'b0;
            mod_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            trig_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_enable) begin
                        state_q  <= ARM;
                        status_q <= 1'b1;
                    end
                end
                ARM: begin
                    state_q <= RUN_L;
                    trig_q  <= 1'b1;
                    mod_q   <= 1'b0;
                    cnt_q   <= act_half_q - CNT_W'(1);
                end
                RUN_L: begin
                    if (half_end) begin
                        state_q <= RUN_H;
                        trig_q  <= 1'b1;
                        mod_q   <= 1'b1;
                        cnt_q   <= act_half_q - CNT_W'(1);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RUN_H: begin
                    if (half_end) begin
                        mod_q <= 1'b0;
                        cnt_q <= half_d - CNT_W'(1);
                        if (bus.i_enable) begin
                            state_q <= RUN_L;
                            trig_q  <= 1'b1;
                        end else begin
                            state_q  <= IDLE;
                            status_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_status      = status_q;
    assign bus.o_trig        = trig_q;
    assign bus.o_mod         = mod_q;
    assign bus.o_period_done = done_q;
    assign bus.o_cfg_ack     = ack_q;
    assign bus.o_cfg_err     = err_q;
    assign bus.o_wait_cnt    = act_wait_q;
    assign bus.o_avg_sel     = {27'd0, act_avg_q};

endmodule

// File: tb/tb_iris_mod_sched.sv
// tb/tb_iris_mod_sched.sv - scoreboard bench for the IRIS modulation scheduler
module tb_iris_mod_sched;

    localparam int CNT_W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    iris_mod_sched_if #(.CNT_W(CNT_W)) bus ();

    iris_mod_sched #(.CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { int gap; logic m; } trig_t;
    typedef struct packed { logic [31:0] w; logic [31:0] a; } ack_t;

    trig_t tq[$];
    int    dq[$];
    ack_t  aq[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_trig(input int gap, input logic m);
        trig_t t;
        t.gap = gap;
        t.m   = m;
        tq.push_back(t);
    endtask

    task automatic exp_done(input int gap);
        dq.push_back(gap);
    endtask

    task automatic exp_ack(input logic [31:0] w, input logic [31:0] a);
        ack_t e;
        e.w = w;
        e.a = a;
        aq.push_back(e);
    endtask

    // Monitor: pops the matching expectation whenever the DUT pulses trig/done/ack
    int    last_trig   = 0;
    logic  status_prev = 1'b0;
    trig_t et;
    ack_t  ea;
    int    ed;
    always @(negedge clk) begin
        if (bus.o_status && !status_prev) last_trig = cyc;
        status_prev = bus.o_status;
        if (bus.o_cfg_ack) begin
            if (aq.size() == 0) check("unexpected_ack", 1, 0);
            else begin
                ea = aq.pop_front();
                check("ack_wait", 64'(bus.o_wait_cnt), 64'(ea.w));
                check("ack_avg", 64'(bus.o_avg_sel), 64'(ea.a));
                check("ack_err", 64'(bus.o_cfg_err), 0);
            end
        end
        if (bus.o_period_done) begin
            if (dq.size() == 0) check("unexpected_done", 1, 0);
            else begin
                ed = dq.pop_front();
                check("done_gap", 64'(cyc - last_trig), 64'(ed));
                check("done_mod", 64'(bus.o_mod), 1);
            end
        end
        if (bus.o_trig) begin
            if (tq.size() == 0) check("unexpected_trig", 1, 0);
            else begin
                et = tq.pop_front();
                check("trig_gap", 64'(cyc - last_trig), 64'(et.gap));
                check("trig_mod", 64'(bus.o_mod), 64'(et.m));
            end
            last_trig = cyc;
        end
    end

    task automatic wait_drain(input string name, input int budget);
        int i;
        i = 0;
        while ((tq.size() + dq.size() + aq.size()) != 0 && i < budget) begin
            @(negedge clk);
            #1;
            i++;
        end
        checks++;
        if ((tq.size() + dq.size() + aq.size()) != 0) begin
            failures++;
            $display("FAIL drain_%s actual_pending=%0d required_pending=0", name,
                     tq.size() + dq.size() + aq.size());
            tq.delete();
            dq.delete();
            aq.delete();
        end
    endtask

    task automatic load_cfg(input logic [31:0] h, input logic [31:0] w, input logic [4:0] a);
        @(posedge clk);
        #1;
        bus.i_cfg_load    = 1'b1;
        bus.i_half_period = h;
        bus.i_wait_cnt    = w;
        bus.i_avg_sel     = a;
        @(posedge clk);
        #1;
        bus.i_cfg_load = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_status"}, 64'(bus.o_status), 0);
        check({tag, "_trig"}, 64'(bus.o_trig), 0);
        check({tag, "_mod"}, 64'(bus.o_mod), 0);
        check({tag, "_done"}, 64'(bus.o_period_done), 0);
        check({tag, "_ack"}, 64'(bus.o_cfg_ack), 0);
        check({tag, "_err"}, 64'(bus.o_cfg_err), 0);
        check({tag, "_wait"}, 64'(bus.o_wait_cnt), 100);
        check({tag, "_avg"}, 64'(bus.o_avg_sel), 4);
    endtask

    initial begin
        bus.i_enable      = 1'b0;
        bus.i_cfg_load    = 1'b0;
        bus.i_half_period = '0;
        bus.i_wait_cnt    = '0;
        bus.i_avg_sel     = '0;

        #12;
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Default timing: 1000-cycle halves
        exp_trig(1, 1'b0);
        exp_trig(1000, 1'b1);
        exp_done(999);
        exp_trig(1000, 1'b0);
        exp_trig(1000, 1'b1);
        exp_done(999);
        exp_trig(1000, 1'b0);
        bus.i_enable = 1'b1;
        wait_drain("default", 6000);

        // Load mid RUN_L: current period keeps 1000, next one runs at 50
        load_cfg(50, 10, 3);
        exp_trig(1000, 1'b1);
        exp_done(999);
        exp_ack(10, 3);
        exp_trig(1000, 1'b0);
        exp_trig(50, 1'b1);
        exp_done(49);
        exp_trig(50, 1'b0);
        wait_drain("retime", 2500);
        check("retime_wait", 64'(bus.o_wait_cnt), 10);
        check("retime_avg", 64'(bus.o_avg_sel), 3);

        // Exact-fit config accepted (10 + 8 + 2 = 20)
        load_cfg(20, 10, 3);
        exp_trig(50, 1'b1);
        exp_done(49);
        exp_ack(10, 3);
        exp_trig(50, 1'b0);
        exp_trig(20, 1'b1);
        exp_done(19);
        exp_trig(20, 1'b0);
        wait_drain("fit", 300);
        check("fit_err", 64'(bus.o_cfg_err), 0);

        // One cycle short: rejected, timing stays at 20
        load_cfg(19, 10, 3);
        exp_trig(20, 1'b1);
        exp_done(19);
        exp_trig(20, 1'b0);
        exp_trig(20, 1'b1);
        exp_done(19);
        exp_trig(20, 1'b0);
        wait_drain("short", 300);
        check("short_err", 64'(bus.o_cfg_err), 1);
        check("short_wait", 64'(bus.o_wait_cnt), 10);

        // Two valid loads in one period: only the later one lands, error clears
        load_cfg(40, 5, 2);
        load_cfg(30, 4, 1);
        exp_trig(20, 1'b1);
        exp_done(19);
        exp_ack(4, 1);
        exp_trig(20, 1'b0);
        exp_trig(30, 1'b1);
        exp_done(29);
        exp_trig(30, 1'b0);
        wait_drain("latest", 300);
        check("latest_err", 64'(bus.o_cfg_err), 0);

        // Valid load overwritten by an overflowing one: rejected
        load_cfg(40, 5, 2);
        load_cfg(100, 32'hFFFF_FFFF, 5'd10);
        exp_trig(30, 1'b1);
        exp_done(29);
        exp_trig(30, 1'b0);
        exp_trig(30, 1'b1);
        exp_done(29);
        exp_trig(30, 1'b0);
        wait_drain("overflow", 400);
        check("overflow_err", 64'(bus.o_cfg_err), 1);
        check("overflow_wait", 64'(bus.o_wait_cnt), 4);
        check("overflow_avg", 64'(bus.o_avg_sel), 1);

        // Disable mid RUN_L: the period completes, then the block goes idle
        bus.i_enable = 1'b0;
        exp_trig(30, 1'b1);
        exp_done(29);
        wait_drain("disable", 200);
        @(posedge clk);
        #1;
        check("disable_status", 64'(bus.o_status), 0);
        check("disable_mod", 64'(bus.o_mod), 0);
        repeat (100) @(negedge clk);
        check("idle_status", 64'(bus.o_status), 0);

        // Restart with the 30-cycle config, then reset mid RUN_H with a load pending
        exp_trig(1, 1'b0);
        exp_trig(30, 1'b1);
        bus.i_enable = 1'b1;
        wait_drain("restart", 200);
        load_cfg(50, 10, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_trig(1, 1'b0);
        exp_trig(1000, 1'b1);
        exp_done(999);
        rst_n = 1'b1;
        wait_drain("postrst", 2500);
        check("postrst_wait", 64'(bus.o_wait_cnt), 100);

        bus.i_enable = 1'b0;
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
